// File: rtl/vjtag_byte_fifo_pkg.sv
// Common definitions for the Virtual-JTAG byte link buffering stage.
package vjtag_byte_fifo_pkg;

    // Byte driven onto the link when the host asks for data and none is queued
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

    // Virtual-JTAG instruction codes that open host sessions
    localparam logic [7:0] IR_INIT_RECV = 8'h41;
    localparam logic [7:0] IR_INIT_SEND = 8'h42;

    // Send response FSM: LOAD is the cycle where send_set is presented
    typedef enum logic {
        SEND_IDLE = 1'b0,
        SEND_LOAD = 1'b1
    } sendState_t;

endpackage

// File: rtl/vjtag_byte_fifo_sync_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through read and occupancy count.
// A pop is applied before a push, so a full FIFO accepts a push on a popping cycle.
module sync_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            wrData,
    input  logic                  pop,
    output logic [7:0]            rdData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_doPop;
    logic                  w_doPush;

    assign w_doPop  = pop && (r_count != '0);
    assign w_doPush = push && ((r_count != FULL_COUNT) || w_doPop);

    assign count  = r_count;
    assign full   = (r_count == FULL_COUNT);
    assign empty  = (r_count == '0);
    assign rdData = (r_count == '0) ? 8'h00 : r_mem[r_rdPtr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
        end
    end

    // Pointers wrap at depth on their own; occupancy tracks accepted pushes and pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vjtag_byte_fifo.sv
// Buffers Virtual-JTAG link bytes into an RX FIFO and answers link send
// requests from a TX FIFO; tracks sticky overflow/underrun and session count.
module vjtag_byte_fifo
    import vjtag_byte_fifo_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] FILL_BYTE  = FILL_BYTE_DEFAULT
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic                recv,
    input  logic [7:0]          recv_data,
    input  logic                init_recv,
    input  logic                init_send,
    input  logic                send,
    output logic                send_set,
    output logic [7:0]          send_data,
    input  logic                rx_re,
    output logic [7:0]          rx_data,
    output logic                rx_empty,
    output logic [DEPTH_LOG2:0] rx_count,
    input  logic                tx_we,
    input  logic [7:0]          tx_data,
    output logic                tx_full,
    output logic [DEPTH_LOG2:0] tx_count,
    output logic                rx_overflow,
    output logic                tx_underrun,
    input  logic                flag_clr,
    output logic [7:0]          rx_sessions
);

    sendState_t  r_sendState;
    sendState_t  w_nextState;
    logic        w_request;
    logic        w_pending;
    logic        w_loadNext;
    logic        w_rxFull;
    logic        w_rxDrop;
    logic        w_txEmpty;
    logic [7:0]  w_txHead;
    logic        r_sendSet;
    logic [7:0]  r_sendData;
    logic        r_rxOverflow;
    logic        r_txUnderrun;
    logic [7:0]  r_rxSessions;

    assign w_request = send | init_send;
    assign w_rxDrop  = recv && w_rxFull && !rx_re;

    sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rxFifo (
        .clk    (m_clock),
        .rst    (p_reset),
        .push   (recv),
        .wrData (recv_data),
        .pop    (rx_re),
        .rdData (rx_data),
        .full   (w_rxFull),
        .empty  (rx_empty),
        .count  (rx_count)
    );

    // The TX head is popped on the edge that enters LOAD, so the byte is on
    // send_data during the LOAD cycle; a full TX FIFO ignores writes outright.
    sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_txFifo (
        .clk    (m_clock),
        .rst    (p_reset),
        .push   (tx_we && !tx_full),
        .wrData (tx_data),
        .pop    (w_loadNext),
        .rdData (w_txHead),
        .full   (tx_full),
        .empty  (w_txEmpty),
        .count  (tx_count)
    );

    // Send FSM state register
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_sendState <= SEND_IDLE;
        end else begin
            r_sendState <= w_nextState;
        end
    end

    // Next-state: a request seen during LOAD is the pending one and is served by the following LOAD
    always_comb begin
        w_nextState = r_sendState;
        w_loadNext  = 1'b0;
        w_pending   = 1'b0;
        case (r_sendState)
            SEND_IDLE: begin
                if (w_request) begin
                    w_nextState = SEND_LOAD;
                    w_loadNext  = 1'b1;
                end
            end
            SEND_LOAD: begin
                w_pending = w_request;
                if (w_pending) begin
                    w_nextState = SEND_LOAD;
                    w_loadNext  = 1'b1;
                end else begin
                    w_nextState = SEND_IDLE;
                end
            end
            default: w_nextState = SEND_IDLE;
        endcase
    end

    // Registered load strobe and byte toward the link
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_sendSet  <= 1'b0;
            r_sendData <= 8'h00;
        end else begin
            r_sendSet <= w_loadNext;
            if (w_loadNext) begin
                r_sendData <= w_txEmpty ? FILL_BYTE : w_txHead;
            end
        end
    end

    // Sticky flags; a setting event outranks a clear on the same cycle
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_rxOverflow <= 1'b0;
            r_txUnderrun <= 1'b0;
        end else begin
            if (w_rxDrop) begin
                r_rxOverflow <= 1'b1;
            end else if (flag_clr) begin
                r_rxOverflow <= 1'b0;
            end
            if (w_loadNext && w_txEmpty) begin
                r_txUnderrun <= 1'b1;
            end else if (flag_clr) begin
                r_txUnderrun <= 1'b0;
            end
        end
    end

    // Host receive session counter, wraps modulo 256
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_rxSessions <= 8'h00;
        end else if (init_recv) begin
            r_rxSessions <= r_rxSessions + 8'h01;
        end
    end

    assign send_set    = r_sendSet;
    assign send_data   = r_sendData;
    assign rx_overflow = r_rxOverflow;
    assign tx_underrun = r_txUnderrun;
    assign rx_sessions = r_rxSessions;

endmodule

// File: tb/tb_vjtag_byte_fifo.sv
// Directed bench for vjtag_byte_fifo with hand-computed expected values.
module tb_vjtag_byte_fifo;

    logic       m_clock = 1'b0;
    logic       p_reset;
    logic       recv;
    logic [7:0] recv_data;
    logic       init_recv;
    logic       init_send;
    logic       send;
    logic       send_set;
    logic [7:0] send_data;
    logic       rx_re;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       tx_we;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       rx_overflow;
    logic       tx_underrun;
    logic       flag_clr;
    logic [7:0] rx_sessions;

    int vectorCount = 0;
    int missCount   = 0;

    vjtag_byte_fifo #(.DEPTH_LOG2(4), .FILL_BYTE(8'h00)) dut (
        .m_clock     (m_clock),
        .p_reset     (p_reset),
        .recv        (recv),
        .recv_data   (recv_data),
        .init_recv   (init_recv),
        .init_send   (init_send),
        .send        (send),
        .send_set    (send_set),
        .send_data   (send_data),
        .rx_re       (rx_re),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_count    (rx_count),
        .tx_we       (tx_we),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .tx_count    (tx_count),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun),
        .flag_clr    (flag_clr),
        .rx_sessions (rx_sessions)
    );

    // Free-running clock, 10 time-unit period
    always #5 m_clock = ~m_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs already set are sampled on the next rising edge; outputs are read 1 unit later
    task automatic applyStimulus();
        @(posedge m_clock);
        #1;
    endtask

    task automatic clearInputs();
        recv = 0; recv_data = 8'h00; init_recv = 0; init_send = 0; send = 0;
        rx_re = 0; tx_we = 0; tx_data = 8'h00; flag_clr = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " send_set"},    32'(send_set),    32'h0);
        checkOutput({tag, " send_data"},   32'(send_data),   32'h00);
        checkOutput({tag, " rx_empty"},    32'(rx_empty),    32'h1);
        checkOutput({tag, " rx_count"},    32'(rx_count),    32'h0);
        checkOutput({tag, " rx_data"},     32'(rx_data),     32'h00);
        checkOutput({tag, " tx_full"},     32'(tx_full),     32'h0);
        checkOutput({tag, " tx_count"},    32'(tx_count),    32'h0);
        checkOutput({tag, " rx_overflow"}, 32'(rx_overflow), 32'h0);
        checkOutput({tag, " tx_underrun"}, 32'(tx_underrun), 32'h0);
        checkOutput({tag, " rx_sessions"}, 32'(rx_sessions), 32'h0);
    endtask

    logic [7:0] rxBytes [3];
    logic [7:0] expHead;

    initial begin
        clearInputs();
        p_reset = 1'b1;
        repeat (2) applyStimulus();
        checkResetValues("reset");
        p_reset = 1'b0;
        applyStimulus();

        // Three received bytes then pops, FWFT order
        rxBytes[0] = 8'h11; rxBytes[1] = 8'h22; rxBytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            recv = 1; recv_data = rxBytes[i];
            applyStimulus();
            if (i == 0) begin
                checkOutput("rx first empty", 32'(rx_empty), 32'h0);
                checkOutput("rx first data", 32'(rx_data), 32'h11);
            end
        end
        recv = 0;
        checkOutput("rx count 3", 32'(rx_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rx pop head", 32'(rx_data), 32'(rxBytes[i]));
            rx_re = 1;
            applyStimulus();
            checkOutput("rx pop count", 32'(rx_count), 32'(2 - i));
        end
        checkOutput("rx drained empty", 32'(rx_empty), 32'h1);
        applyStimulus();
        checkOutput("rx pop on empty count", 32'(rx_count), 32'h0);
        checkOutput("rx pop on empty flag", 32'(rx_overflow), 32'h0);
        rx_re = 0;

        // Fill RX, overflow, then push+pop while full
        for (int i = 0; i < 16; i++) begin
            recv = 1; recv_data = 8'h40 + 8'(i);
            applyStimulus();
        end
        checkOutput("rx full count", 32'(rx_count), 32'd16);
        checkOutput("rx full flag before drop", 32'(rx_overflow), 32'h0);
        recv_data = 8'hEE;
        applyStimulus();
        checkOutput("rx drop count", 32'(rx_count), 32'd16);
        checkOutput("rx overflow set", 32'(rx_overflow), 32'h1);
        recv_data = 8'h77; rx_re = 1;
        applyStimulus();
        recv = 0; rx_re = 0;
        checkOutput("rx push+pop count", 32'(rx_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            expHead = (i == 15) ? 8'h77 : 8'h41 + 8'(i);
            checkOutput("rx drain head", 32'(rx_data), 32'(expHead));
            rx_re = 1;
            applyStimulus();
        end
        rx_re = 0;
        checkOutput("rx drain empty", 32'(rx_empty), 32'h1);
        flag_clr = 1;
        applyStimulus();
        flag_clr = 0;
        checkOutput("rx overflow cleared", 32'(rx_overflow), 32'h0);

        // TX: two bytes answered by init_send then send
        tx_we = 1; tx_data = 8'hA5; applyStimulus();
        tx_data = 8'h5A; applyStimulus();
        tx_we = 0;
        checkOutput("tx count 2", 32'(tx_count), 32'd2);
        checkOutput("tx idle send_set", 32'(send_set), 32'h0);
        init_send = 1; applyStimulus(); init_send = 0;
        checkOutput("init_send set", 32'(send_set), 32'h1);
        checkOutput("init_send data", 32'(send_data), 32'hA5);
        checkOutput("init_send count", 32'(tx_count), 32'd1);
        applyStimulus();
        checkOutput("send_set one cycle", 32'(send_set), 32'h0);
        send = 1; applyStimulus(); send = 0;
        checkOutput("send set", 32'(send_set), 32'h1);
        checkOutput("send data", 32'(send_data), 32'h5A);
        checkOutput("send count", 32'(tx_count), 32'd0);
        applyStimulus();
        checkOutput("no underrun yet", 32'(tx_underrun), 32'h0);

        // Underrun on empty, clear, clear versus coincident underrun
        send = 1; applyStimulus(); send = 0;
        checkOutput("underrun set_pulse", 32'(send_set), 32'h1);
        checkOutput("underrun fill", 32'(send_data), 32'h00);
        checkOutput("underrun flag", 32'(tx_underrun), 32'h1);
        flag_clr = 1; applyStimulus();
        checkOutput("underrun cleared", 32'(tx_underrun), 32'h0);
        send = 1; applyStimulus(); send = 0; flag_clr = 0;
        checkOutput("set beats clear", 32'(tx_underrun), 32'h1);

        // Write and pop on empty TX in the same cycle: fill byte out, write kept
        flag_clr = 1; applyStimulus(); flag_clr = 0;
        tx_we = 1; tx_data = 8'h3C; send = 1;
        applyStimulus();
        tx_we = 0; send = 0;
        checkOutput("no bypass data", 32'(send_data), 32'h00);
        checkOutput("no bypass stored", 32'(tx_count), 32'd1);
        checkOutput("no bypass underrun", 32'(tx_underrun), 32'h1);
        send = 1; applyStimulus(); send = 0;
        checkOutput("stored byte sent", 32'(send_data), 32'h3C);
        flag_clr = 1; applyStimulus(); flag_clr = 0;

        // Back-to-back requests with two bytes queued
        tx_we = 1; tx_data = 8'hC1; applyStimulus();
        tx_data = 8'hC2; applyStimulus();
        tx_we = 0;
        send = 1; applyStimulus();
        checkOutput("b2b first set", 32'(send_set), 32'h1);
        checkOutput("b2b first data", 32'(send_data), 32'hC1);
        applyStimulus(); send = 0;
        checkOutput("b2b second set", 32'(send_set), 32'h1);
        checkOutput("b2b second data", 32'(send_data), 32'hC2);
        checkOutput("b2b count", 32'(tx_count), 32'd0);
        applyStimulus();
        checkOutput("b2b end set", 32'(send_set), 32'h0);
        checkOutput("b2b no underrun", 32'(tx_underrun), 32'h0);

        // TX full: extra write ignored
        tx_we = 1;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'h80 + 8'(i);
            applyStimulus();
        end
        tx_we = 0;
        checkOutput("tx full", 32'(tx_full), 32'h1);
        checkOutput("tx full count", 32'(tx_count), 32'd16);

        // Session counter wrap
        init_recv = 1;
        repeat (255) applyStimulus();
        checkOutput("sessions 255", 32'(rx_sessions), 32'd255);
        applyStimulus();
        init_recv = 0;
        checkOutput("sessions wrap", 32'(rx_sessions), 32'd0);

        // Reset mid-stream with both FIFOs holding data and a request pending
        recv = 1; recv_data = 8'h99; applyStimulus();
        recv = 0; send = 1; applyStimulus();
        checkOutput("pre-reset set", 32'(send_set), 32'h1);
        checkOutput("pre-reset data", 32'(send_data), 32'h80);
        checkOutput("pre-reset rx count", 32'(rx_count), 32'd1);
        #2;
        p_reset = 1'b1;
        #1;
        checkResetValues("mid reset");
        send = 0;
        applyStimulus();
        p_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("post-reset no send_set", 32'(send_set), 32'h0);
        end
        checkOutput("post-reset tx count", 32'(tx_count), 32'h0);
        checkOutput("post-reset rx empty", 32'(rx_empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/vjtag_byte_fifo.md
# vjtag_byte_fifo

Buffering stage between the Virtual-JTAG byte link and user logic, entirely in the `m_clock` domain. It consumes the link's receive strobes (`recv`, `recv_data`) into an RX FIFO and answers the link's send requests (`init_send`, `send`) by popping a TX FIFO onto `send_set` and `send_data`. User logic sees two plain synchronous FIFO ports plus sticky overflow and underrun flags.

## Interface
- `DEPTH_LOG2`, default 4: log2 of the depth of each FIFO. Depth is 2**DEPTH_LOG2 entries.
- `FILL_BYTE`, default 8'h00: byte sent when a send request finds the TX FIFO empty.

Ports:
- `m_clock` in 1: the only clock.
- `p_reset` in 1: reset, asynchronous and active-high.
- `recv` in 1: single-cycle strobe from the link; `recv_data` is valid on that cycle.
- `recv_data` in 8: received byte.
- `init_recv` in 1: start of a host receive session (IR 0x41). Used only for the session counter.
- `init_send` in 1: start of a host send session (IR 0x42). Treated as a send request.
- `send` in 1: single-cycle strobe; the link needs the next TX byte.
- `send_set` out 1: one-cycle load strobe to the link.
- `send_data` out 8: byte to load. Valid while `send_set` is 1.
- `rx_re` in 1: pop the RX FIFO.
- `rx_data` out 8: RX head, first-word fall-through.
- `rx_empty` out 1: RX FIFO is empty.
- `rx_count` out DEPTH_LOG2+1: RX occupancy.
- `tx_we` in 1: push `tx_data` into the TX FIFO.
- `tx_data` in 8: byte to transmit.
- `tx_full` out 1: TX FIFO is full.
- `tx_count` out DEPTH_LOG2+1: TX occupancy.
- `rx_overflow` out 1: sticky; set when a received byte was dropped.
- `tx_underrun` out 1: sticky; set when `FILL_BYTE` was sent.
- `flag_clr` in 1: clears both sticky flags.
- `rx_sessions` out 8: count of `init_recv` pulses, wraps 255 to 0.

## Operation
- RX push on `recv`. When the RX FIFO is full the byte is dropped and `rx_overflow` is set.
- RX full with `recv` and `rx_re` on the same cycle: the pop is applied first, so the push is accepted and the count is unchanged.
- `rx_re` while `rx_empty` is 1: ignored, and no flag is set.
- TX push on `tx_we`. When `tx_full` is 1 the write is ignored; this is a user error and no flag is set.
- TX FIFO empty with `tx_we` and a pop on the same cycle: there is no bypass. The pop sees empty and sends `FILL_BYTE`; the written byte is stored.
- Send request is `send | init_send`. Each request is handled by exactly one response.
- Send response FSM states:
  - IDLE: on a request, go to LOAD.
  - LOAD: if the TX FIFO is not empty, pop its head into `send_data`; otherwise drive `FILL_BYTE` and set `tx_underrun`. `send_set`=1 for this cycle. Return to IDLE.
- A request that arrives while in LOAD is latched as pending and serviced on the next LOAD. At most one request is pending; further requests are merged into it.
- `flag_clr` and a flag-setting event on the same cycle: set wins.
- Counters are modular with a DEPTH_LOG2-bit address. Pointers wrap at depth; occupancy saturates at depth by construction.
- Reset mid-transfer: both FIFOs are emptied, pending requests dropped, FSM returns to IDLE.

## Timing
- Reset values:
  - `send_set`=0, `send_data`=8'h00.
  - `rx_empty`=1, `rx_count`=0, `rx_data`=8'h00.
  - `tx_full`=0, `tx_count`=0.
  - Both flags 0, `rx_sessions`=0.
- `recv` at cycle N: `rx_empty` falls and `rx_data` is valid at N+1.
- `rx_re` at N: the next head (or `rx_empty`=1) appears at N+1.
- Send request at N: `send_set`=1 with `send_data` at N+1, for exactly one cycle.
- Back-to-back requests at N and N+1: `send_set` pulses at N+1 and N+2.
- All outputs are registered except `rx_data`, which is the RAM read of the head pointer (FWFT).

## Structure
- Shared constants: `FILL_BYTE` default and the IR codes 8'h41 and 8'h42, in the project's common definitions package.
- One sub-module, `sync_byte_fifo`: parameterised depth, synchronous single clock, FWFT read, with `count`, `full` and `empty` outputs. It is instantiated twice, once for RX and once for TX.
- The top level holds the send FSM, the pending bit, the sticky flags and the session counter.

## Test plan
- Reset, then 3 `recv` strobes with 8'h11, 8'h22, 8'h33, then pops → `rx_data` sequence 11, 22, 33; `rx_count` 3→0; `rx_empty` returns to 1.
- Fill RX to 16 entries (DEPTH_LOG2=4), then a 17th `recv` → byte dropped and `rx_overflow`=1. Then `recv` with `rx_re` on the same cycle → accepted, `rx_count` stays at 16.
- `tx_we` with 8'hA5 and 8'h5A, then `init_send`, then `send` → `send_set` pulses carrying A5 then 5A, each one cycle after its request. `tx_count` reaches 0.
- `send` with the TX FIFO empty → `send_data`=8'h00 and `tx_underrun`=1. `flag_clr` then clears it; `flag_clr` coincident with another underrun keeps it set.
- `send` on two consecutive cycles with 2 bytes queued → two consecutive `send_set` pulses, in order, with no byte lost. 255 `init_recv` pulses followed by one more → `rx_sessions` wraps to 0.
- `p_reset` asserted mid-stream with both FIFOs partially full and a request pending → all outputs at reset values immediately. After release, no spurious `send_set`.
